multiplier_32fp: RTL and testbench



---
 rtl/fp32_pkg.sv | 49 ++++
 rtl/fp32_round.sv | 40 ++++
 rtl/multiplier_32fp.sv | 237 +++++++++++++++++++++++
 tb/tb_multiplier_32fp.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// ---------------------------------------------------------------------------
// fp32_pkg
// Shared definitions for the binary32 multiplier: field widths, exponent bias,
// special encodings, the controller state type and operand classification.
// ---------------------------------------------------------------------------
package fp32_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int SIG_W  = MAN_W + 1;       // significand with hidden bit
    localparam int PROD_W = 2 * SIG_W;       // full significand product
    localparam int XE_W   = EXP_W + 2;       // signed exponent with headroom
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] INF  = 32'h7F80_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_MULT   = 3'd2,
        S_NORM   = 3'd3,
        S_ROUND  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Result class decided from the operands alone; CLS_NORMAL means the
    // arithmetic path (multiply, normalise, round, range check) decides.
    typedef enum logic [1:0] {
        CLS_NORMAL = 2'd0,
        CLS_NAN    = 2'd1,
        CLS_INF    = 2'd2,
        CLS_ZERO   = 2'd3
    } cls_t;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    // Subnormals are flushed, so any zero exponent counts as zero.
    function automatic logic is_zero(input logic [31:0] x);
        return (x[30:23] == 8'h00);
    endfunction

endpackage

// File: rtl/fp32_round.sv
// ---------------------------------------------------------------------------
// fp32_round
// Combinational round-to-nearest-even for a normalised 24-bit significand.
// Ports:
//   sig      in  24  normalised significand (bit 23 is the hidden one)
//   guard    in   1  first discarded bit
//   sticky   in   1  OR of all remaining discarded bits
//   exp_in   in  10  signed biased exponent before rounding
//   man      out 23  rounded mantissa (hidden bit stripped)
//   exp_out  out 10  signed biased exponent after rounding
// ---------------------------------------------------------------------------
module fp32_round
    import fp32_pkg::*;
(
    input  logic [SIG_W-1:0]        sig,
    input  logic                    guard,
    input  logic                    sticky,
    input  logic signed [XE_W-1:0]  exp_in,
    output logic [MAN_W-1:0]        man,
    output logic signed [XE_W-1:0]  exp_out
);

    logic           round_up;
    logic [SIG_W:0] sum;

    always_comb begin
        // Round up above half, or exactly at half when the kept LSB is odd.
        round_up = guard & (sticky | sig[0]);
        sum      = {1'b0, sig} + {{SIG_W{1'b0}}, round_up};
        if (sum[SIG_W]) begin
            // 1.111..1 rounded up to 10.000..0: mantissa wraps to zero.
            man     = '0;
            exp_out = exp_in + 10'sd1;
        end else begin
            man     = sum[MAN_W-1:0];
            exp_out = exp_in;
        end
    end

endmodule

// File: rtl/multiplier_32fp.sv
// ---------------------------------------------------------------------------
// multiplier_32fp
// Multi-cycle IEEE-754 binary32 multiplier, round-to-nearest-even,
// flush-to-zero on subnormal inputs and on underflowing results.
// One operation takes six cycles (IDLE capture through DONE).
// Ports:
//   clk          in   1  rising-edge clock
//   rst_n        in   1  synchronous reset, active HIGH
//   a_i, b_i     in  32  binary32 operands, captured in IDLE when start_i=1
//   start_i      in   1  launch request (level, sampled only in IDLE)
//   done_o       out  1  one-cycle pulse in DONE; result valid
//   nan_o        out  1  result is canonical NaN
//   inifinit_o   out  1  result is inf because an operand was inf
//   overflow_o   out  1  finite operands overflowed to +-inf
//   underflow_o  out  1  nonzero result flushed to +-0
//   product_o    out 32  binary32 product, held until the next DONE
//
// state  | meaning
// IDLE   | wait for start_i, capture operands
// UNPACK | classify operands, form significands and exponent sum
// MULT   | 24x24 significand multiply
// NORM   | one-position normalisation, extract guard/sticky
// ROUND  | round, range check, register result and flags
// DONE   | done_o pulse, back to IDLE
// ---------------------------------------------------------------------------
module multiplier_32fp
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        start_i,
    output logic        done_o,
    output logic        nan_o,
    output logic        inifinit_o,
    output logic        overflow_o,
    output logic        underflow_o,
    output logic [31:0] product_o
);

    state_t state_q, state_d;

    logic [31:0]              a_q, b_q;
    logic                     sign_q;
    cls_t                     cls_q;
    logic [SIG_W-1:0]         sig_a_q, sig_b_q;
    logic signed [XE_W-1:0]   exp_q;
    logic [PROD_W-1:0]        prod_q;
    logic [SIG_W-1:0]         nsig_q;
    logic                     guard_q, sticky_q;
    logic                     done_q, nan_q, inf_q, ovf_q, unf_q;
    logic [31:0]              product_q;

    // UNPACK combinational results
    cls_t                     cls_d;
    logic signed [XE_W-1:0]   exp_sum_d;

    // NORM combinational results
    logic [SIG_W-1:0]         nsig_d;
    logic                     guard_d, sticky_d;
    logic signed [XE_W-1:0]   nexp_d;

    // ROUND combinational results
    logic [MAN_W-1:0]         r_man;
    logic signed [XE_W-1:0]   r_exp;
    logic [31:0]              res_d;
    logic                     nan_d, inf_d, ovf_d, unf_d;

    // -----------------------------------------------------------------------
    // Controller
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_i) state_d = S_UNPACK;
            S_UNPACK: state_d = S_MULT;
            S_MULT:   state_d = S_NORM;
            S_NORM:   state_d = S_ROUND;
            S_ROUND:  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath combinational stages
    // -----------------------------------------------------------------------
    always_comb begin
        cls_d = CLS_NORMAL;
        if (is_nan(a_q) || is_nan(b_q) ||
            (is_inf(a_q) && is_zero(b_q)) || (is_inf(b_q) && is_zero(a_q))) begin
            cls_d = CLS_NAN;
        end else if (is_inf(a_q) || is_inf(b_q)) begin
            cls_d = CLS_INF;
        end else if (is_zero(a_q) || is_zero(b_q)) begin
            cls_d = CLS_ZERO;
        end
        exp_sum_d = $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]})
                  - $signed(XE_W'(BIAS));
    end

    // Both significands lie in [1,2), so the product lies in [1,4) and at
    // most one right shift is ever needed.
    always_comb begin
        if (prod_q[PROD_W-1]) begin
            nsig_d   = prod_q[PROD_W-1 -: SIG_W];
            guard_d  = prod_q[PROD_W-1-SIG_W];
            sticky_d = |prod_q[PROD_W-2-SIG_W:0];
            nexp_d   = exp_q + 10'sd1;
        end else begin
            nsig_d   = prod_q[PROD_W-2 -: SIG_W];
            guard_d  = prod_q[PROD_W-2-SIG_W];
            sticky_d = |prod_q[PROD_W-3-SIG_W:0];
            nexp_d   = exp_q;
        end
    end

    fp32_round u_round (
        .sig     (nsig_q),
        .guard   (guard_q),
        .sticky  (sticky_q),
        .exp_in  (exp_q),
        .man     (r_man),
        .exp_out (r_exp)
    );

    // Final result selection; the flag assignments are exclusive by
    // construction because each branch sets at most one of them.
    always_comb begin
        res_d = '0;
        nan_d = 1'b0;
        inf_d = 1'b0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        case (cls_q)
            CLS_NAN: begin
                res_d = QNAN;
                nan_d = 1'b1;
            end
            CLS_INF: begin
                res_d = INF | {sign_q, 31'd0};
                inf_d = 1'b1;
            end
            CLS_ZERO: begin
                res_d = {sign_q, 31'd0};
            end
            default: begin
                if (r_exp >= 10'sd255) begin
                    res_d = INF | {sign_q, 31'd0};
                    ovf_d = 1'b1;
                end else if (r_exp <= 10'sd0) begin
                    res_d = {sign_q, 31'd0};
                    unf_d = 1'b1;
                end else begin
                    res_d = {sign_q, r_exp[EXP_W-1:0], r_man};
                end
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            cls_q     <= CLS_NORMAL;
            sig_a_q   <= '0;
            sig_b_q   <= '0;
            exp_q     <= '0;
            prod_q    <= '0;
            nsig_q    <= '0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            done_q    <= 1'b0;
            nan_q     <= 1'b0;
            inf_q     <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        a_q <= a_i;
                        b_q <= b_i;
                    end
                end
                S_UNPACK: begin
                    sign_q  <= a_q[31] ^ b_q[31];
                    cls_q   <= cls_d;
                    sig_a_q <= {1'b1, a_q[MAN_W-1:0]};
                    sig_b_q <= {1'b1, b_q[MAN_W-1:0]};
                    exp_q   <= exp_sum_d;
                end
                S_MULT: begin
                    prod_q <= PROD_W'(sig_a_q) * PROD_W'(sig_b_q);
                end
                S_NORM: begin
                    nsig_q   <= nsig_d;
                    guard_q  <= guard_d;
                    sticky_q <= sticky_d;
                    exp_q    <= nexp_d;
                end
                S_ROUND: begin
                    product_q <= res_d;
                    nan_q     <= nan_d;
                    inf_q     <= inf_d;
                    ovf_q     <= ovf_d;
                    unf_q     <= unf_d;
                    done_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done_o      = done_q;
    assign nan_o       = nan_q;
    assign inifinit_o  = inf_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
    assign product_o   = product_q;

endmodule

// File: tb/tb_multiplier_32fp.sv
module tb_multiplier_32fp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a_i, b_i;
    logic        start_i;
    logic        done_o, nan_o, inifinit_o, overflow_o, underflow_o;
    logic [31:0] product_o;

    int total = 0;
    int bad   = 0;

    multiplier_32fp dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_i         (a_i),
        .b_i         (b_i),
        .start_i     (start_i),
        .done_o      (done_o),
        .nan_o       (nan_o),
        .inifinit_o  (inifinit_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o),
        .product_o   (product_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] flags();
        return {28'd0, nan_o, inifinit_o, overflow_o, underflow_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer product, leading-one search, then
    // round-half-even by comparing the discarded remainder with one half.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] ma, mb, p, q, rem, half;
        int msb, sh, e;
        bit found;
        ma = {24'd0, 1'b1, a[22:0]};
        mb = {24'd0, 1'b1, b[22:0]};
        p  = ma * mb;
        msb = 0;
        found = 1'b0;
        for (int k = 47; k >= 0; k--) begin
            if (!found && p[k]) begin
                msb = k;
                found = 1'b1;
            end
        end
        sh   = msb - 23;
        q    = p >> sh;
        rem  = p & ((48'd1 << sh) - 48'd1);
        half = 48'd1 << (sh - 1);
        e    = int'(a[30:23]) + int'(b[30:23]) - 127 + msb - 46;
        if (rem > half || (rem == half && q[0])) q = q + 48'd1;
        if (q[24]) begin
            q = q >> 1;
            e++;
        end
        return {a[31] ^ b[31], e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rnd_normal();
        logic [7:0] e;
        e = 8'($urandom_range(180, 70));
        return {1'($urandom_range(1, 0)), e, 23'($urandom)};
    endfunction

    // Called at a negedge with the DUT in IDLE; returns at the negedge after DONE.
    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_p, input logic [3:0] exp_f);
        int n;
        a_i = a;
        b_i = b;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 1;
        while (done_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, n, 32'd5);
        chk({tag, " product"}, product_o, exp_p);
        chk({tag, " flags"}, flags(), {28'd0, exp_f});
        @(negedge clk);
        chk({tag, " pulse"}, {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int n, seen;

        rst_n = 1'b1;
        start_i = 1'b1;
        a_i = 32'h4000_0000;
        b_i = 32'h4000_0000;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("reset product", product_o, 32'd0);
        chk("reset flags", flags(), 32'd0);
        chk("reset done", {31'd0, done_o}, 32'd0);
        rst_n = 1'b0;
        start_i = 1'b0;
        @(negedge clk);

        // flags: {nan, inf, overflow, underflow}
        op("2x3",        32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'b0000);
        op("1.5x-2.5",   32'h3FC0_0000, 32'hC020_0000, 32'hC070_0000, 4'b0000);
        op("round lsb",  32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 4'b0000);
        op("tie up",     32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 4'b0000);
        op("tie even",   32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004, 4'b0000);
        op("near one",   32'h3F7F_FFFF, 32'h3F80_0001, 32'h3F80_0000, 4'b0000);
        op("inf x 0",    32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000);
        op("nan in",     32'hFFC0_0001, 32'h4000_0000, 32'h7FC0_0000, 4'b1000);
        op("-inf x 2",   32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0100);
        op("inf x -inf", 32'h7F80_0000, 32'hFF80_0000, 32'hFF80_0000, 4'b0100);
        op("-0 x 2",     32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 4'b0000);
        op("subn x 2",   32'h0000_0001, 32'hC000_0000, 32'h8000_0000, 4'b0000);
        op("overflow",   32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'b0010);
        op("-overflow",  32'hFF00_0000, 32'h7F00_0000, 32'hFF80_0000, 4'b0010);
        op("max x 1",    32'h7F7F_FFFF, 32'h3F80_0000, 32'h7F7F_FFFF, 4'b0000);
        op("max x 1+",   32'h7F7F_FFFF, 32'h3F80_0001, 32'h7F80_0000, 4'b0010);
        op("underflow",  32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'b0001);
        op("min normal", 32'h2000_0000, 32'h2000_0000, 32'h0080_0000, 4'b0000);
        op("below min",  32'h2000_0000, 32'h9F80_0000, 32'h8000_0000, 4'b0001);

        // Reset while the multiply is in flight.
        a_i = 32'h4000_0000;
        b_i = 32'h4040_0000;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done_o === 1'b1) seen++;
            @(negedge clk);
        end
        chk("abort no done", seen, 32'd0);
        chk("abort product", product_o, 32'd0);
        chk("abort flags", flags(), 32'd0);
        op("after abort", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'b0000);

        // Back-to-back random normal-range vectors with start_i held high.
        ra = rnd_normal();
        rb = rnd_normal();
        a_i = ra;
        b_i = rb;
        start_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (done_o !== 1'b1 && n < 20);
            chk($sformatf("rnd%0d %08h*%08h", i, ra, rb), product_o, ref_mul(ra, rb));
            chk($sformatf("rnd%0d flags", i), flags(), 32'd0);
            chk($sformatf("rnd%0d spacing", i), n, (i == 0) ? 32'd5 : 32'd6);
            ra = rnd_normal();
            rb = rnd_normal();
            a_i = ra;
            b_i = rb;
        end
        start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("idle after run", {31'd0, done_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
